// File: rtl/sargantana_icache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sargantana_icache_miss_ctrl
// Purpose  : Instruction-cache lookup / miss controller. It sequences the tag
//            compare and the line refill, chooses the victim way, and handles
//            kills that arrive while a refill is in flight.
// Options  : SARGANTANA_ICACHE_FLUSH_EN adds a whole-cache invalidate walk
//            (FLUSH state, flush_i / flush_busy_o / valid_clr_o / flush_idx_o).
// Revision : 1.0 - initial release
// ============================================================================
module sargantana_icache_miss_ctrl #(
  parameter int ICACHE_N_WAY = 4,
  parameter int ICACHE_DEPTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    kill_i,
  input  logic                    tag_valid_i,
  output logic                    cmp_enable_o,
  input  logic [ICACHE_N_WAY-1:0] cline_hit_i,
  input  logic [ICACHE_N_WAY-1:0] way_valid_bits_i,
  output logic                    rsp_valid_o,
  output logic                    ifill_req_valid_o,
  input  logic                    ifill_req_ready_i,
  input  logic                    ifill_resp_valid_i,
  output logic [ICACHE_N_WAY-1:0] way_we_o
`ifdef SARGANTANA_ICACHE_FLUSH_EN
  ,
  input  logic                    flush_i,
  output logic                    flush_busy_o,
  output logic                    valid_clr_o,
  output logic [$clog2(ICACHE_DEPTH)-1:0] flush_idx_o
`endif
);

  localparam int c_way_w = $clog2(ICACHE_N_WAY);
  localparam int c_idx_w = $clog2(ICACHE_DEPTH);

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_compare   = 3'd1;
  localparam logic [2:0] c_st_miss_req  = 3'd2;
  localparam logic [2:0] c_st_wait_fill = 3'd3;
  localparam logic [2:0] c_st_write     = 3'd4;
  localparam logic [2:0] c_st_kill_wait = 3'd5;
`ifdef SARGANTANA_ICACHE_FLUSH_EN
  localparam logic [2:0] c_st_flush     = 3'd6;
`endif

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [c_way_w-1:0] r_rr_ptr;
  logic [c_way_w-1:0] r_victim;
  logic               r_victim_rr;
  logic               w_free_found;
  logic [c_way_w-1:0] w_free_idx;
  logic               w_miss;
  logic               w_any_hit;
`ifdef SARGANTANA_ICACHE_FLUSH_EN
  logic [c_idx_w-1:0] r_flush_idx;
  logic               w_flush_last;
`endif

  assign w_any_hit = |cline_hit_i;
  // A miss is only committed when the physical tag is present and no kill.
  assign w_miss    = (r_state == c_st_compare) && tag_valid_i && !w_any_hit && !kill_i;

`ifdef SARGANTANA_ICACHE_FLUSH_EN
  assign w_flush_last = (r_flush_idx == c_idx_w'(ICACHE_DEPTH - 1));
`endif

  // Find the lowest-index invalid way of the indexed set.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
      if (!way_valid_bits_i[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = c_way_w'(i);
      end
    end
  end

  // Next-state logic; kill takes precedence over hit and handshakes.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
`ifdef SARGANTANA_ICACHE_FLUSH_EN
        if (flush_i) w_next_state = c_st_flush;
        else
`endif
        if (req_valid_i) w_next_state = c_st_compare;
      end
      c_st_compare: begin
        if (kill_i)           w_next_state = c_st_idle;
        else if (tag_valid_i) w_next_state = w_any_hit ? c_st_idle : c_st_miss_req;
      end
      c_st_miss_req: begin
        if (kill_i)                 w_next_state = c_st_idle;
        else if (ifill_req_ready_i) w_next_state = c_st_wait_fill;
      end
      c_st_wait_fill: begin
        // A kill coinciding with the returning line drops it right away,
        // otherwise the line still has to be drained in KILL_WAIT.
        if (kill_i)                  w_next_state = ifill_resp_valid_i ? c_st_idle : c_st_kill_wait;
        else if (ifill_resp_valid_i) w_next_state = c_st_write;
      end
      c_st_write: begin
        // The write always lands; a kill only suppresses the replay.
        w_next_state = kill_i ? c_st_idle : c_st_compare;
      end
      c_st_kill_wait: begin
        if (ifill_resp_valid_i) w_next_state = c_st_idle;
      end
`ifdef SARGANTANA_ICACHE_FLUSH_EN
      c_st_flush: begin
        if (w_flush_last) w_next_state = c_st_idle;
      end
`endif
      default: w_next_state = c_st_idle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= c_st_idle;
    else       r_state <= w_next_state;
  end

  // Victim latch on a committed miss: free way first, else round-robin.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_victim    <= '0;
      r_victim_rr <= 1'b0;
    end else if (w_miss) begin
      r_victim    <= w_free_found ? w_free_idx : r_rr_ptr;
      r_victim_rr <= !w_free_found;
    end
  end

  // Round-robin pointer advances only when a write consumed it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
`ifdef SARGANTANA_ICACHE_FLUSH_EN
    end else if ((r_state == c_st_flush) && w_flush_last) begin
      r_rr_ptr <= '0;
`endif
    end else if ((r_state == c_st_write) && r_victim_rr) begin
      r_rr_ptr <= r_rr_ptr + c_way_w'(1);
    end
  end

`ifdef SARGANTANA_ICACHE_FLUSH_EN
  // Flush set counter: cleared on entry, one set per busy cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                        r_flush_idx <= '0;
    else if (r_state == c_st_flush)   r_flush_idx <= r_flush_idx + c_idx_w'(1);
    else                              r_flush_idx <= '0;
  end

  assign flush_busy_o = (r_state == c_st_flush);
  assign valid_clr_o  = (r_state == c_st_flush);
  assign flush_idx_o  = r_flush_idx;
  assign req_ready_o  = (r_state == c_st_idle) && !flush_i;
`else
  assign req_ready_o  = (r_state == c_st_idle);
`endif

  assign cmp_enable_o = (r_state == c_st_compare);
  assign rsp_valid_o  = (r_state == c_st_compare) && tag_valid_i && w_any_hit && !kill_i;
  // Request is withdrawn in the kill cycle so no handshake can slip through.
  assign ifill_req_valid_o = (r_state == c_st_miss_req) && !kill_i;
  assign way_we_o = (r_state == c_st_write)
                    ? ({{(ICACHE_N_WAY-1){1'b0}}, 1'b1} << r_victim)
                    : '0;

endmodule
`default_nettype wire

// File: tb/tb_sargantana_icache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sargantana_icache_miss_ctrl
// Purpose  : Self-checking bench for the icache miss controller: directed
//            vector table, reset corner cases, optional flush walk, and
//            randomized transactions against a replacement-policy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sargantana_icache_miss_ctrl;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic       kill_i = 1'b0;
  logic       tag_valid_i = 1'b0;
  logic       cmp_enable_o;
  logic [3:0] cline_hit_i = '0;
  logic [3:0] way_valid_bits_i = '0;
  logic       rsp_valid_o;
  logic       ifill_req_valid_o;
  logic       ifill_req_ready_i = 1'b0;
  logic       ifill_resp_valid_i = 1'b0;
  logic [3:0] way_we_o;
`ifdef SARGANTANA_ICACHE_FLUSH_EN
  logic       flush_i = 1'b0;
  logic       flush_busy_o;
  logic       valid_clr_o;
  logic [5:0] flush_idx_o;
`endif

  always #5 clk = ~clk;

  sargantana_icache_miss_ctrl #(.ICACHE_N_WAY(4), .ICACHE_DEPTH(64)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .kill_i             (kill_i),
    .tag_valid_i        (tag_valid_i),
    .cmp_enable_o       (cmp_enable_o),
    .cline_hit_i        (cline_hit_i),
    .way_valid_bits_i   (way_valid_bits_i),
    .rsp_valid_o        (rsp_valid_o),
    .ifill_req_valid_o  (ifill_req_valid_o),
    .ifill_req_ready_i  (ifill_req_ready_i),
    .ifill_resp_valid_i (ifill_resp_valid_i),
    .way_we_o           (way_we_o)
`ifdef SARGANTANA_ICACHE_FLUSH_EN
    ,
    .flush_i            (flush_i),
    .flush_busy_o       (flush_busy_o),
    .valid_clr_o        (valid_clr_o),
    .flush_idx_o        (flush_idx_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rr_model = 0;   // replacement pointer of the reference model

  typedef struct {
    logic [3:0] vb;
    logic [3:0] hit;
    int         kill_ph;   // 0 none, 1 compare, 2 miss request, 3 wait fill
    int         tag_wait;
    int         rdy_dly;
    int         resp_dly;
    logic       exp_rsp;
    logic [3:0] exp_we;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference victim choice: first empty way, else the round-robin pointer.
  function automatic logic [3:0] model_we(input logic [3:0] vb);
    int v;
    v = rr_model;
    for (int i = 3; i >= 0; i--) if (!vb[i]) v = i;
    model_we = 4'(1 << v);
  endfunction

  // One full lookup transaction; called at a negative clock edge in IDLE.
  task automatic do_txn(input logic [3:0] vb, input logic [3:0] hit, input int kill_ph,
                        input int tag_wait, input int rdy_dly, input int resp_dly,
                        input logic exp_rsp, input logic [3:0] exp_we);
    logic miss;
    req_valid_i = 1'b1;
    #1 chk("idle_ready", req_ready_o, 1);
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (tag_wait) begin
      #1 chk("cmp_wait_en", cmp_enable_o, 1);
      chk("cmp_wait_rsp", rsp_valid_o, 0);
      @(negedge clk);
    end
    tag_valid_i = 1'b1; cline_hit_i = hit; way_valid_bits_i = vb; kill_i = (kill_ph == 1);
    #1 chk("rsp_valid", rsp_valid_o, exp_rsp);
    chk("cmp_no_ifill", ifill_req_valid_o, 0);
    @(negedge clk);
    tag_valid_i = 1'b0; cline_hit_i = '0; kill_i = 1'b0;
    miss = (hit == 4'b0) && (kill_ph != 1);
    if (!miss) begin
      #1 chk("back_idle", req_ready_o, 1);
      chk("no_ifill", ifill_req_valid_o, 0);
      return;
    end
    if (kill_ph == 2) begin
      kill_i = 1'b1;
      @(negedge clk);
      kill_i = 1'b0;
      #1 chk("kreq_idle", req_ready_o, 1);
      chk("kreq_noreq", ifill_req_valid_o, 0);
      @(negedge clk);
      #1 chk("kreq_noreq2", ifill_req_valid_o, 0);
      return;
    end
    repeat (rdy_dly) begin
      #1 chk("ifill_hold", ifill_req_valid_o, 1);
      @(negedge clk);
    end
    ifill_req_ready_i = 1'b1;
    #1 chk("ifill_hs", ifill_req_valid_o, 1);
    @(negedge clk);
    ifill_req_ready_i = 1'b0;
    #1 chk("wait_noreq", ifill_req_valid_o, 0);
    if (kill_ph == 3) begin
      kill_i = 1'b1;
      @(negedge clk);
      kill_i = 1'b0;
      repeat (resp_dly) begin
        #1 chk("kwait_we", way_we_o, 0);
        @(negedge clk);
      end
      ifill_resp_valid_i = 1'b1;
      #1 chk("kwait_drop", way_we_o, 0);
      @(negedge clk);
      ifill_resp_valid_i = 1'b0;
      #1 chk("kwait_idle", req_ready_o, 1);
      chk("kwait_we_after", way_we_o, 0);
      return;
    end
    repeat (resp_dly) begin
      #1 chk("wait_we", way_we_o, 0);
      @(negedge clk);
    end
    ifill_resp_valid_i = 1'b1;
    #1 chk("resp_we", way_we_o, 0);
    @(negedge clk);
    ifill_resp_valid_i = 1'b0;
    #1 chk("write_we", way_we_o, exp_we);
    chk("write_no_rsp", rsp_valid_o, 0);
    @(negedge clk);
    tag_valid_i = 1'b1; cline_hit_i = exp_we;
    #1 chk("replay_en", cmp_enable_o, 1);
    chk("replay_rsp", rsp_valid_o, 1);
    chk("replay_we", way_we_o, 0);
    @(negedge clk);
    tag_valid_i = 1'b0; cline_hit_i = '0;
    #1 chk("replay_idle", req_ready_o, 1);
    if (vb == 4'hF) rr_model = (rr_model + 1) % 4;
  endtask

  initial begin
    tbl[0]  = '{4'hF, 4'b0100, 0, 1, 0, 0, 1'b1, 4'b0000};
    tbl[1]  = '{4'hB, 4'b0000, 0, 0, 3, 1, 1'b0, 4'b0100};
    tbl[2]  = '{4'hF, 4'b0000, 0, 0, 0, 0, 1'b0, 4'b0001};
    tbl[3]  = '{4'hF, 4'b0000, 0, 2, 1, 2, 1'b0, 4'b0010};
    tbl[4]  = '{4'hF, 4'b0000, 0, 0, 0, 0, 1'b0, 4'b0100};
    tbl[5]  = '{4'hF, 4'b0000, 0, 0, 2, 0, 1'b0, 4'b1000};
    tbl[6]  = '{4'hF, 4'b0000, 0, 0, 0, 1, 1'b0, 4'b0001};
    tbl[7]  = '{4'hF, 4'b0010, 1, 0, 0, 0, 1'b0, 4'b0000};
    tbl[8]  = '{4'hF, 4'b0000, 2, 0, 0, 0, 1'b0, 4'b0000};
    tbl[9]  = '{4'hF, 4'b0000, 3, 0, 1, 2, 1'b0, 4'b0000};
    tbl[10] = '{4'hF, 4'b0000, 0, 0, 0, 0, 1'b0, 4'b0010};
    tbl[11] = '{4'h0, 4'b0000, 0, 0, 0, 0, 1'b0, 4'b0001};
    tbl[12] = '{4'hE, 4'b0000, 0, 0, 1, 0, 1'b0, 4'b0001};
    tbl[13] = '{4'h7, 4'b0000, 0, 1, 0, 0, 1'b0, 4'b1000};

    // Reset state
    #1 rst_i = 1'b1;
    #2;
    chk("rst_ready", req_ready_o, 1);
    chk("rst_cmp", cmp_enable_o, 0);
    chk("rst_rsp", rsp_valid_o, 0);
    chk("rst_ifill", ifill_req_valid_o, 0);
    chk("rst_we", way_we_o, 0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    rr_model = 0;

    // Directed vectors
    for (int i = 0; i < 14; i++)
      do_txn(tbl[i].vb, tbl[i].hit, tbl[i].kill_ph, tbl[i].tag_wait, tbl[i].rdy_dly,
             tbl[i].resp_dly, tbl[i].exp_rsp, tbl[i].exp_we);

    // Reset while a refill request is pending, then a stray response
    @(negedge clk);
    req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0; tag_valid_i = 1'b1; cline_hit_i = '0; way_valid_bits_i = 4'hF;
    @(negedge clk);
    tag_valid_i = 1'b0;
    #1 chk("pre_rst_ifill", ifill_req_valid_o, 1);
    #1 rst_i = 1'b1;
    #1 chk("mid_rst_ifill", ifill_req_valid_o, 0);
    chk("mid_rst_ready", req_ready_o, 1);
    chk("mid_rst_cmp", cmp_enable_o, 0);
    chk("mid_rst_we", way_we_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    rr_model = 0;
    ifill_resp_valid_i = 1'b1;
    #1 chk("stray_resp_we", way_we_o, 0);
    @(negedge clk);
    ifill_resp_valid_i = 1'b0;
    #1 chk("stray_resp_idle", req_ready_o, 1);
    chk("stray_resp_we2", way_we_o, 0);
    @(negedge clk);
    do_txn(4'hF, 4'b0, 0, 0, 0, 0, 1'b0, model_we(4'hF));
    do_txn(4'hF, 4'b0, 0, 0, 0, 0, 1'b0, model_we(4'hF));

`ifdef SARGANTANA_ICACHE_FLUSH_EN
    // Whole-cache flush walk; pointer returns to way 0 afterwards
    @(negedge clk);
    flush_i = 1'b1; req_valid_i = 1'b1;
    #1 chk("flush_req_ready", req_ready_o, 0);
    @(negedge clk);
    flush_i = 1'b0; req_valid_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1 chk("flush_busy", flush_busy_o, 1);
      chk("flush_idx", flush_idx_o, i);
      chk("flush_clr", valid_clr_o, 1);
      chk("flush_ready", req_ready_o, 0);
      @(negedge clk);
    end
    #1 chk("flush_done", flush_busy_o, 0);
    chk("flush_idle", req_ready_o, 1);
    rr_model = 0;
    @(negedge clk);
    do_txn(4'hF, 4'b0, 0, 0, 0, 0, 1'b0, model_we(4'hF));
`endif

    // Randomized transactions against the model
    for (int n = 0; n < 60; n++) begin
      logic [3:0] vb, hit, ewe;
      int kp;
      logic ersp;
      vb  = ($urandom % 2 == 0) ? 4'hF : 4'($urandom_range(0, 15));
      hit = ($urandom % 3 == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
      kp  = $urandom_range(0, 5);
      if (kp > 3) kp = 0;
      ersp = (hit != 4'b0) && (kp != 1);
      ewe  = ((hit == 4'b0) && (kp == 0)) ? model_we(vb) : 4'b0;
      do_txn(vb, hit, kp, $urandom_range(0, 2), $urandom_range(0, 3),
             $urandom_range(0, 3), ersp, ewe);
      if ($urandom % 2 == 0) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
